// File: rtl/fpga_receiver_state.sv
// Receiving end of the board-to-board req/ack serial link: synchronises the remote
// strobe/data, runs the 4-phase handshake per symbol and assembles LSB-first bytes.
module fpga_receiver_state #(
    parameter int DATA_BITS      = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 reqIn,
    input  logic                 dataIn,
    input  logic                 readAck,
    output logic                 ack,
    output logic [DATA_BITS-1:0] dataOut,
    output logic                 dataValid,
    output logic                 busy,
    output logic                 overrun,
    output logic                 frameError
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, START_HI, BIT_WAIT, BIT_HI, DONE} state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] req_sync, data_sync;
    logic                   req_s, data_s;
    logic [CW-1:0]          bit_cnt, bit_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic [TW-1:0]          tmo_cnt;
    logic                   timeout;

    // Both lines share the same synchroniser depth so data stays aligned with its strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_sync  <= '0;
            data_sync <= '0;
        end else begin
            req_sync  <= {req_sync[SYNC_STAGES-2:0], reqIn};
            data_sync <= {data_sync[SYNC_STAGES-2:0], dataIn};
        end
    end

    assign req_s  = req_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        timeout    = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
        if (timeout) begin
            // Abort wins over any handshake progress in the same cycle.
            state_next = IDLE;
            bit_next   = '0;
            shift_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    bit_next = '0;
                    if (req_s) state_next = START_HI;
                end
                START_HI: begin
                    if (!req_s) begin
                        state_next = BIT_WAIT;
                        bit_next   = '0;
                        shift_next = '0;
                    end
                end
                BIT_WAIT: begin
                    if (req_s) begin
                        shift_next = shift_reg | ({{(DATA_BITS-1){1'b0}}, data_s} << bit_cnt);
                        state_next = BIT_HI;
                    end
                end
                BIT_HI: begin
                    if (!req_s) begin
                        bit_next   = bit_cnt + CW'(1);
                        state_next = (bit_next == CW'(DATA_BITS)) ? DONE : BIT_WAIT;
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt    <= '0;
            shift_reg  <= '0;
            tmo_cnt    <= '0;
            ack        <= 1'b0;
            busy       <= 1'b0;
            frameError <= 1'b0;
        end else begin
            bit_cnt    <= bit_next;
            shift_reg  <= shift_next;
            tmo_cnt    <= (state_next != state || state == IDLE) ? '0 : tmo_cnt + TW'(1);
            ack        <= (state_next == START_HI) || (state_next == BIT_HI);
            busy       <= (state_next != IDLE);
            frameError <= timeout;
        end
    end

    // Consumer side: a new byte always wins over a coincident read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dataOut   <= '0;
            dataValid <= 1'b0;
            overrun   <= 1'b0;
        end else if (state == DONE) begin
            dataOut   <= shift_reg;
            dataValid <= 1'b1;
            overrun   <= readAck ? 1'b0 : (dataValid | overrun);
        end else if (readAck && dataValid) begin
            dataValid <= 1'b0;
            overrun   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fpga_receiver_state.sv
// Directed bench for fpga_receiver_state: drives the remote req/data side, checks
// handshake latency and scoreboards received bytes against what was sent.
module tb_fpga_receiver_state;

    localparam int DB = 8;
    localparam int SS = 2;
    localparam int TO = 1024;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          reqIn = 1'b0;
    logic          dataIn = 1'b0;
    logic          readAck = 1'b0;
    logic          ack, dataValid, busy, overrun, frameError;
    logic [DB-1:0] dataOut;

    int            n_vec = 0;
    int            n_fail = 0;
    int            fe_count = 0;
    int            ack_pulses = 0;
    logic [DB-1:0] exp_q[$];

    fpga_receiver_state #(.DATA_BITS(DB), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .reqIn(reqIn), .dataIn(dataIn), .readAck(readAck),
        .ack(ack), .dataOut(dataOut), .dataValid(dataValid), .busy(busy),
        .overrun(overrun), .frameError(frameError)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frameError === 1'b1) fe_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 4-phase handshake as the remote transmitter would perform it.
    task automatic hs(input logic bitval, input logic glitch);
        int n;
        dataIn = bitval;
        reqIn  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (ack !== 1'b1 && n < 40);
        check("ack_rise_lat", n, SS + 1);
        if (ack === 1'b1) ack_pulses++;
        if (glitch) dataIn = ~dataIn;
        reqIn = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (ack !== 1'b0 && n < 40);
        check("ack_fall_lat", n, SS + 1);
    endtask

    task automatic send_frame(input logic [DB-1:0] b, input int nbits, input logic rd,
                              output logic dv_at_fall);
        dv_at_fall = 1'bx;
        if (nbits == DB) exp_q.push_back(b);
        hs(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) hs(b[i], 1'b1);
        if (nbits == DB) begin
            dv_at_fall = dataValid;
            readAck = rd;
            @(negedge clk);
            readAck = 1'b0;
            check("dataOut", dataOut, exp_q.pop_front());
            check("dataValid_after_done", dataValid, 1);
        end
    endtask

    task automatic read_pulse();
        @(negedge clk);
        readAck = 1'b1;
        @(negedge clk);
        readAck = 1'b0;
    endtask

    initial begin
        logic dv;
        int   n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_dataOut", dataOut, 0);
        check("rst_dataValid", dataValid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frameError", frameError, 0);
        reset = 1'b1;
        @(negedge clk);

        // Basic byte with latency checks
        ack_pulses = 0;
        send_frame(8'hA5, DB, 1'b0, dv);
        check("a5_dv_before", dv, 0);
        check("a5_ack_pulses", ack_pulses, 9);
        check("a5_busy", busy, 0);
        check("a5_overrun", overrun, 0);
        check("a5_frameError_cnt", fe_count, 0);
        read_pulse();
        @(negedge clk);
        check("a5_read_dv", dataValid, 0);
        read_pulse();
        check("idle_read_dv", dataValid, 0);
        check("idle_read_data", dataOut, 8'hA5);

        // Back-to-back without read
        send_frame(8'h3C, DB, 1'b0, dv);
        check("3c_overrun", overrun, 0);
        send_frame(8'hC3, DB, 1'b0, dv);
        check("c3_overrun", overrun, 1);
        read_pulse();
        check("c3_read_dv", dataValid, 0);
        check("c3_read_ov", overrun, 0);

        // Read coinciding with DONE
        send_frame(8'h7E, DB, 1'b0, dv);
        send_frame(8'h81, DB, 1'b1, dv);
        check("81_dv_before", dv, 1);
        check("81_overrun", overrun, 0);
        read_pulse();
        check("81_read_dv", dataValid, 0);

        // Timeout after 3 data bits
        send_frame(8'h07, 3, 1'b0, dv);
        check("tmo_busy_before", busy, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (frameError !== 1'b1 && n < TO + 100);
        check("tmo_latency", n, TO);
        check("tmo_ack", ack, 0);
        check("tmo_busy", busy, 0);
        check("tmo_dv_untouched", dataValid, 0);
        check("tmo_data_untouched", dataOut, 8'h81);
        @(negedge clk);
        check("tmo_pulse_width", frameError, 0);
        check("tmo_fe_cnt", fe_count, 1);
        send_frame(8'h5A, DB, 1'b0, dv);
        check("5a_overrun", overrun, 0);
        read_pulse();

        // Reset during bit 5 of 0xFF
        send_frame(8'hFF, 4, 1'b0, dv);
        dataIn = 1'b1;
        reqIn  = 1'b1;
        repeat (SS + 1) @(negedge clk);
        check("mid_ack_hi", ack, 1);
        check("mid_busy_hi", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_ack", ack, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_dataOut", dataOut, 0);
        check("mid_rst_dv", dataValid, 0);
        check("mid_rst_ov", overrun, 0);
        check("mid_rst_fe", frameError, 0);
        reqIn  = 1'b0;
        dataIn = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_frame(8'h12, DB, 1'b0, dv);
        check("12_dv_before", dv, 0);
        check("12_busy", busy, 0);
        check("final_fe_cnt", fe_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
